// File: rtl/bram_add_seq.sv
// Sequencer that reads operand RAMs A and B over 0..len-1, adds each pair and writes the sum to RAM C.
// Optional BRAM_ADD_SAT_EN: on carry the written sum saturates to all-ones instead of wrapping.
module bram_add_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              ena_ab,
    output logic [ADDR_W-1:0] addr_ab,
    input  logic [DATA_W-1:0] douta_a,
    input  logic [DATA_W-1:0] douta_b,
    output logic              ena_c,
    output logic              wea_c,
    output logic [ADDR_W-1:0] addr_c,
    output logic [DATA_W-1:0] dina_c,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        wcnt;
    logic [DATA_W:0]   sum_w;
    logic              last_wait;
    logic              last_elem;

    assign sum_w     = {1'b0, douta_a} + {1'b0, douta_b};
    assign last_wait = (state == S_WAIT) && (wcnt == 2'd1);
    assign last_elem = (idx == len_q - ADDR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Strobes and status decode straight from the state so reset forces them low at once.
    always_comb begin
        state_nxt = state;
        ena_ab    = 1'b0;
        ena_c     = 1'b0;
        wea_c     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (len != '0) ? S_READ : S_DONE;
            end
            S_READ: begin
                ena_ab    = 1'b1;
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wcnt == 2'd1) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                ena_c     = 1'b1;
                wea_c     = 1'b1;
                busy      = 1'b1;
                state_nxt = last_elem ? S_DONE : S_READ;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address and data registers only move on entry to their active state, so they hold in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            idx     <= '0;
            wcnt    <= '0;
            addr_ab <= '0;
            addr_c  <= '0;
            dina_c  <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ovf     <= 1'b0;
                        idx     <= '0;
                        addr_ab <= '0;
                        if (len != '0) len_q <= len;
                    end
                end
                S_READ: wcnt <= 2'(RD_LAT);
                S_WAIT: begin
                    wcnt <= wcnt - 2'd1;
                    if (last_wait) begin
                        addr_c <= idx;
                        ovf    <= ovf | sum_w[DATA_W];
`ifdef BRAM_ADD_SAT_EN
                        dina_c <= sum_w[DATA_W] ? {DATA_W{1'b1}} : sum_w[DATA_W-1:0];
`else
                        dina_c <= sum_w[DATA_W-1:0];
`endif
                    end
                end
                S_WRITE: begin
                    if (!last_elem) begin
                        idx     <= idx + ADDR_W'(1);
                        addr_ab <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_add_seq.sv
// Directed bench: two sequencers (read latency 1 and 2) against behavioural A/B/C RAM models.
module tb_bram_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start2;
    logic [7:0]  len1, len2;
    logic        ena_ab1, ena_ab2, ena_c1, ena_c2, wea_c1, wea_c2;
    logic [7:0]  addr_ab1, addr_ab2, addr_c1, addr_c2;
    logic [15:0] douta_a1, douta_b1, douta_a2, douta_b2;
    logic [15:0] dina_c1, dina_c2;
    logic        busy1, busy2, done1, done2, ovf1, ovf2;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] mem_c1 [0:255];
    logic [15:0] mem_c2 [0:255];
    logic [15:0] ra2, rb2;

    int cyc = 0;
    int rd1 = 0, wr1 = 0, wr2 = 0, ovl1 = 0;
    int wlog_addr1 [0:1023];
    int wlog_cyc2  [0:1023];
    int nchk = 0, nfail = 0;

    always #5 clk = ~clk;

    bram_add_seq #(.ADDR_W(8), .DATA_W(16), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .len(len1),
        .ena_ab(ena_ab1), .addr_ab(addr_ab1), .douta_a(douta_a1), .douta_b(douta_b1),
        .ena_c(ena_c1), .wea_c(wea_c1), .addr_c(addr_c1), .dina_c(dina_c1),
        .busy(busy1), .done(done1), .ovf(ovf1)
    );

    bram_add_seq #(.ADDR_W(8), .DATA_W(16), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .len(len2),
        .ena_ab(ena_ab2), .addr_ab(addr_ab2), .douta_a(douta_a2), .douta_b(douta_b2),
        .ena_c(ena_c2), .wea_c(wea_c2), .addr_c(addr_c2), .dina_c(dina_c2),
        .busy(busy2), .done(done2), .ovf(ovf2)
    );

    // RAM models: one output register for latency 1, an extra stage for latency 2.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ena_ab1) begin
            douta_a1 <= mem_a[addr_ab1];
            douta_b1 <= mem_b[addr_ab1];
            rd1      <= rd1 + 1;
        end
        if (ena_ab1 && wea_c1) ovl1 <= ovl1 + 1;
        if (ena_c1 && wea_c1) begin
            mem_c1[addr_c1]         <= dina_c1;
            wlog_addr1[wr1 & 1023]  <= int'(addr_c1);
            wr1                     <= wr1 + 1;
        end
        if (ena_ab2) begin
            ra2 <= mem_a[addr_ab2];
            rb2 <= mem_b[addr_ab2];
        end
        douta_a2 <= ra2;
        douta_b2 <= rb2;
        if (ena_c2 && wea_c2) begin
            mem_c2[addr_c2]        <= dina_c2;
            wlog_cyc2[wr2 & 1023]  <= cyc;
            wr2                    <= wr2 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle1(input string tag);
        chk({tag, " done"},    32'(done1),    0);
        chk({tag, " busy"},    32'(busy1),    0);
        chk({tag, " ena_ab"},  32'(ena_ab1),  0);
        chk({tag, " ena_c"},   32'(ena_c1),   0);
        chk({tag, " wea_c"},   32'(wea_c1),   0);
        chk({tag, " addr_ab"}, 32'(addr_ab1), 0);
        chk({tag, " addr_c"},  32'(addr_c1),  0);
        chk({tag, " dina_c"},  32'(dina_c1),  0);
        chk({tag, " ovf"},     32'(ovf1),     0);
    endtask

    // n counts cycles after the start cycle; bc counts busy cycles seen. rp re-pulses start,
    // ra drops reset at that cycle and aborts the run.
    task automatic run(input int w, input logic [7:0] l, input int rp, input int ra,
                       output int n, output int bc);
        n  = 0;
        bc = 0;
        @(negedge clk);
        if (w == 1) begin start1 = 1'b1; len1 = l; end
        else        begin start2 = 1'b1; len2 = l; end
        while (1) begin
            @(negedge clk);
            n++;
            start1 = 1'b0;
            start2 = 1'b0;
            if (n == rp) begin start1 = 1'b1; len1 = 8'd1; end
            if (n == ra) begin
                rst_n = 1'b0;
                #1;
                chk_idle1("async reset");
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (w == 1 ? busy1 : busy2) bc++;
            if (w == 1 ? done1 : done2) break;
            if (n > 2000) begin
                chk("run timeout", 32'(n), 0);
                break;
            end
        end
    endtask

    initial begin
        int n, bc, b, r;
        rst_n  = 1'b0;
        start1 = 1'b0; start2 = 1'b0;
        len1   = '0;   len2   = '0;
        for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
        repeat (3) @(negedge clk);
        chk_idle1("reset");
        chk("reset busy2", 32'(busy2), 0);
        chk("reset ena_ab2", 32'(ena_ab2), 0);
        rst_n = 1'b1;

        // len=4 with a carry on the last element
        mem_a[0] = 16'd1;  mem_a[1] = 16'd2;  mem_a[2] = 16'd3;  mem_a[3] = 16'hFFFF;
        mem_b[0] = 16'd10; mem_b[1] = 16'd20; mem_b[2] = 16'd30; mem_b[3] = 16'd2;
        run(1, 8'd4, -1, -1, n, bc);
        chk("t1 done latency", 32'(n), 13);
        chk("t1 busy cycles", 32'(bc), 12);
        chk("t1 ovf", 32'(ovf1), 1);
        chk("t1 C0", 32'(mem_c1[0]), 32'd11);
        chk("t1 C1", 32'(mem_c1[1]), 32'd22);
        chk("t1 C2", 32'(mem_c1[2]), 32'd33);
`ifdef BRAM_ADD_SAT_EN
        chk("t1 C3 sat", 32'(mem_c1[3]), 32'hFFFF);
`else
        chk("t1 C3 wrap", 32'(mem_c1[3]), 32'h0001);
`endif

        // start re-pulsed mid-run is ignored; the new run clears ovf
        mem_a[3] = 16'd4; mem_b[3] = 16'h0100;
        b = wr1;
        run(1, 8'd4, 5, -1, n, bc);
        chk("t2 done latency", 32'(n), 13);
        chk("t2 writes", 32'(wr1 - b), 4);
        chk("t2 ovf cleared", 32'(ovf1), 0);
        chk("t2 C3", 32'(mem_c1[3]), 32'h0104);
        @(negedge clk);
        chk("t2 idle after done", 32'(busy1), 0);

        // len=0: straight to done with no RAM traffic
        b = wr1; r = rd1;
        run(1, 8'd0, -1, -1, n, bc);
        chk("t3 done latency", 32'(n), 1);
        chk("t3 busy cycles", 32'(bc), 0);
        chk("t3 reads", 32'(rd1 - r), 0);
        chk("t3 writes", 32'(wr1 - b), 0);
        chk("t3 ovf", 32'(ovf1), 0);

        // read latency 2
        mem_a[0] = 16'h0100; mem_a[1] = 16'h0200; mem_a[2] = 16'h0300;
        mem_b[0] = 16'h0100; mem_b[1] = 16'h0200; mem_b[2] = 16'h0300;
        b = wr2;
        run(2, 8'd3, -1, -1, n, bc);
        chk("t4 done latency", 32'(n), 13);
        chk("t4 busy cycles", 32'(bc), 12);
        chk("t4 ovf", 32'(ovf2), 0);
        chk("t4 C0", 32'(mem_c2[0]), 32'h0200);
        chk("t4 C1", 32'(mem_c2[1]), 32'h0400);
        chk("t4 C2", 32'(mem_c2[2]), 32'h0600);
        chk("t4 period 0-1", 32'(wlog_cyc2[(b + 1) & 1023] - wlog_cyc2[b & 1023]), 4);
        chk("t4 period 1-2", 32'(wlog_cyc2[(b + 2) & 1023] - wlog_cyc2[(b + 1) & 1023]), 4);

        // write-strobe order over len=8, plus no read/write overlap
        for (int i = 0; i < 8; i++) begin mem_a[i] = 16'(i); mem_b[i] = 16'(100 + i); end
        b = wr1; r = ovl1;
        run(1, 8'd8, -1, -1, n, bc);
        chk("t5 writes", 32'(wr1 - b), 8);
        for (int k = 0; k < 8; k++) chk("t5 addr order", 32'(wlog_addr1[(b + k) & 1023]), 32'(k));
        chk("t5 rd/wr overlap", 32'(ovl1 - r), 0);
        chk("t5 C7", 32'(mem_c1[7]), 32'd114);

        // full range len=255: addresses 0..254 only
        for (int i = 0; i < 256; i++) begin mem_a[i] = 16'(i); mem_b[i] = 16'(2 * i); end
        b = wr1;
        run(1, 8'd255, -1, -1, n, bc);
        chk("t6 done latency", 32'(n), 766);
        chk("t6 writes", 32'(wr1 - b), 255);
        chk("t6 first addr", 32'(wlog_addr1[b & 1023]), 0);
        chk("t6 last addr", 32'(wlog_addr1[(b + 254) & 1023]), 254);
        chk("t6 C254", 32'(mem_c1[254]), 32'd762);
        chk("t6 ovf", 32'(ovf1), 0);

        // reset during WAIT of the second element, then a single-element run
        run(1, 8'd4, -1, 5, n, bc);
        chk("t7 ovf after reset", 32'(ovf1), 0);
        mem_a[0] = 16'h1234; mem_b[0] = 16'h0001;
        b = wr1; r = rd1;
        run(1, 8'd1, -1, -1, n, bc);
        chk("t7 done latency", 32'(n), 4);
        chk("t7 writes", 32'(wr1 - b), 1);
        chk("t7 reads", 32'(rd1 - r), 1);
        chk("t7 write addr", 32'(wlog_addr1[b & 1023]), 0);
        chk("t7 C0", 32'(mem_c1[0]), 32'h1235);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/bram_add_seq.md
Name: bram_add_seq

Overview:
- Initiator-side controller for the single-port block-RAM wrappers.
- Sequences reads of operand RAMs A and B over an address range. Adds each 16-bit pair and writes the sum to result RAM C at the same address.
- Drives the RAM-side ena/wea/addra/dina pins and consumes douta; sits between the top-level control and three BRAM instances.

Parameters:
- ADDR_W, 8, BRAM address width.
- DATA_W, 16, BRAM data width.
- RD_LAT, 1, BRAM read latency in cycles (1..3), from ena to valid douta.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse begins a run; ignored while busy=1.
- len  input  ADDR_W  number of elements to process from address 0; sampled on start.
- ena_ab  output  1  read enable to RAMs A and B.
- addr_ab  output  ADDR_W  read address to RAMs A and B.
- douta_a  input  DATA_W  read data from RAM A.
- douta_b  input  DATA_W  read data from RAM B.
- ena_c  output  1  enable to RAM C.
- wea_c  output  1  write enable to RAM C.
- addr_c  output  ADDR_W  write address to RAM C.
- dina_c  output  DATA_W  write data to RAM C.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- ovf  output  1  sticky: some sum in the run produced a carry out.

Behaviour:
- Reset (rst_n=0, async): state IDLE; all outputs 0; idx=0, wait counter=0, sum register=0.
- Clock and reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- IDLE:
  - start=1 with len!=0: latch len, clear ovf, idx=0, busy=1, go to READ.
  - start=1 with len=0: go to DONE directly, with no RAM access.
- READ (1 cycle): ena_ab=1, addr_ab=idx; go to WAIT with wait counter=RD_LAT.
- WAIT (RD_LAT cycles): ena_ab=0; decrement counter.
  - On the last WAIT cycle, douta_a/douta_b are valid.
  - Register {carry,sum} = douta_a + douta_b (DATA_W+1 bits).
  - ovf |= carry. Go to WRITE.
- WRITE (1 cycle): ena_c=1, wea_c=1, addr_c=idx, dina_c=registered sum (low DATA_W bits).
  - If idx==len-1, go to DONE; else idx++ and go to READ.
- DONE (1 cycle): done=1, busy=0; return to IDLE.
- Per-element period: 2+RD_LAT cycles.
- Run latency from the start cycle to the done cycle: len*(2+RD_LAT)+1 cycles.
- Outputs outside their active state:
  - ena/wea are 0.
  - Addresses and dina hold their last value.
  - ovf holds until the next accepted start.
- start while busy: ignored, no effect on len, idx or ovf.
- start in the DONE cycle: ignored; a new start is accepted from IDLE only.
- len=2^ADDR_W-1: addresses 0..254 processed (ADDR_W=8); idx never wraps mid-run.
- Reset mid-run: immediate return to IDLE, all outputs 0; partially written C contents are not restored.
- Read and write buses are separate, so A, B and C may be distinct RAMs. C must not alias A or B.

Optional Feature:
- Macro: BRAM_ADD_SAT_EN.
- Defined: on carry, the WRITE data is all-ones (saturating add); ovf still sets.
- Undefined: the sum wraps modulo 2^DATA_W.

Test Plan:
- RD_LAT=1, len=4, A=[1,2,3,0xFFFF], B=[10,20,30,2] -> C=[11,22,33,0x0001] (wrap) or C[3]=0xFFFF with BRAM_ADD_SAT_EN; ovf=1; done asserted exactly 13 cycles after start; busy high for the 12 cycles between.
- len=0, start pulse -> done one cycle later; ena_ab, ena_c and wea_c never asserted; busy stays 0; ovf=0.
- RD_LAT=2, len=3, A=B=[0x0100,0x0200,0x0300] -> C=[0x0200,0x0400,0x0600]; ovf=0; element period 4 cycles; done 13 cycles after start.
- start re-pulsed at cycle 5 of a len=4 run -> ignored; run completes normally; a second start after done is accepted and clears ovf.
- rst_n dropped during WAIT of element 2 -> all outputs 0 asynchronously; after release, start with len=1 processes address 0 only.
- Write-strobe check over a len=8 run -> ena_c/wea_c high exactly 8 times, with addr_c=0..7 in order; ena_ab never high in the same cycle as wea_c.
